// File: rtl/acc_pkg.sv
// Shared types and sizing for the accelerator dispatch queue.
// Each queue entry holds an offloaded instruction together with its captured scalar operands.
package acc_pkg;

    localparam int unsigned ACC_XLEN       = 64;
    localparam int unsigned ACC_DEPTH      = 8;
    localparam int unsigned ACC_TRANS_ID_W = 3;
    // One extra wrap bit so that a full queue and an empty queue can be told apart.
    localparam int unsigned ACC_PTR_W      = $clog2(ACC_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]               insn;
        logic [ACC_XLEN-1:0]       rs1;
        logic [ACC_XLEN-1:0]       rs2;
        logic [ACC_TRANS_ID_W-1:0] trans_id;
    } acc_req_t;

endpackage

// File: rtl/acc_dispatch_queue.sv
// Buffers offloaded vector instructions between issue and the accelerator.
// An entry is released to the accelerator only once commit has confirmed it; flush drops speculative entries.
module acc_dispatch_queue
    import acc_pkg::*;
#(
    parameter int unsigned XLEN       = ACC_XLEN,
    parameter int unsigned DEPTH      = ACC_DEPTH,
    parameter int unsigned TRANS_ID_W = ACC_TRANS_ID_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_insn_i,
    input  logic [XLEN-1:0]       issue_rs1_i,
    input  logic [XLEN-1:0]       issue_rs2_i,
    input  logic [TRANS_ID_W-1:0] issue_trans_id_i,
    input  logic                  commit_valid_i,
    input  logic [TRANS_ID_W-1:0] commit_trans_id_i,
    output logic                  acc_req_valid_o,
    input  logic                  acc_req_ready_i,
    output logic [31:0]           acc_req_insn_o,
    output logic [XLEN-1:0]       acc_req_rs1_o,
    output logic [XLEN-1:0]       acc_req_rs2_o,
    output logic [TRANS_ID_W-1:0] acc_req_trans_id_o,
    output logic                  empty_o,
    output logic                  commit_err_o
);

    localparam int unsigned PTR_W = ACC_PTR_W;
    localparam int unsigned IDX_W = PTR_W - 1;

    acc_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, cmt_q, tail_q;
    logic [PTR_W-1:0] cmt_d;
    logic             commit_err_q;
    logic             full, enq, cmt_adv, cmt_bad, deq;
    acc_req_t         wr_entry, head_entry, cmt_entry;

    // [head,cmt) is committed and may dispatch; [cmt,tail) is still speculative.
    assign full          = (tail_q - head_q) == PTR_W'(DEPTH);
    assign issue_ready_o = !full && !flush_i;
    assign enq           = issue_valid_i && issue_ready_o;

    assign cmt_entry = mem_q[cmt_q[IDX_W-1:0]];
    assign cmt_adv   = commit_valid_i && (cmt_q != tail_q);
    assign cmt_bad   = commit_valid_i && (!cmt_adv || (cmt_entry.trans_id != commit_trans_id_i));
    assign cmt_d     = cmt_q + PTR_W'(cmt_adv);

    assign acc_req_valid_o = cmt_q != head_q;
    assign deq             = acc_req_valid_o && acc_req_ready_i;

    assign head_entry         = mem_q[head_q[IDX_W-1:0]];
    assign acc_req_insn_o     = head_entry.insn;
    assign acc_req_rs1_o      = head_entry.rs1;
    assign acc_req_rs2_o      = head_entry.rs2;
    assign acc_req_trans_id_o = head_entry.trans_id;

    assign empty_o      = head_q == tail_q;
    assign commit_err_o = commit_err_q;

    assign wr_entry = '{insn: issue_insn_i, rs1: issue_rs1_i, rs2: issue_rs2_i,
                        trans_id: issue_trans_id_i};

    // A flush rewinds tail onto the commit pointer as already advanced by this cycle's commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q       <= '0;
            cmt_q        <= '0;
            tail_q       <= '0;
            commit_err_q <= 1'b0;
        end else begin
            head_q <= head_q + PTR_W'(deq);
            cmt_q  <= cmt_d;
            tail_q <= flush_i ? cmt_d : tail_q + PTR_W'(enq);
            if (cmt_bad) begin
                commit_err_q <= 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[tail_q[IDX_W-1:0]] <= wr_entry;
        end
    end

endmodule
